// File: rtl/seg7_pkg.sv
// Shared definitions for the eight-digit seven-segment scan driver.
// Digit count, FSM encoding, segment table and helpers.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] ALL_OFF = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Active-low segments g..a, indexed by nibble value (entry 15 leftmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  // Index of the most significant nonzero nibble, 0 when all are zero.
  function automatic logic [2:0] top_nz_digit(input logic [31:0] d);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (d[4*k +: 4] != 4'h0) r = 3'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// CPU-side write port of the seven-segment scan driver.
// Master drives a display word plus decimal-point mask.
interface seg7_scan_driver_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  dp_mask;

  modport master (
    output wr_en,
    output wr_data,
    output dp_mask
  );

  modport slave (
    input wr_en,
    input wr_data,
    input dp_mask
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to 7-segment decoder, active-low.
// Bit 0 = segment a ... bit 6 = segment g.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern.
  always_comb seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed hex display with blanking and tear-free updates.
// Define SEG7_BLANK_LEADING_EN to suppress leading-zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus,
  output logic [7:0]         seg_an,
  output logic [7:0]         seg_cat,
  output logic               frame_sync
);

  localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYCLES - 1);
  localparam logic [31:0] SHOW_LAST  = 32'(SCAN_DIV - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        boundary;

  logic        wr_q, wr_prev_q;
  logic [31:0] data_q;
  logic [7:0]  dpm_q;
  logic        wr_rise;

  logic [31:0] shadow_data_q, shadow_data_d;
  logic [7:0]  shadow_dp_q, shadow_dp_d;
  logic        pending_q, pending_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic [7:0]  disp_dp_q, disp_dp_d;

  logic [7:0]  an_q, an_d;
  logic [7:0]  cat_q, cat_d;
  logic        sync_q, sync_d;

  logic [3:0]  nib;
  logic [6:0]  seg;
  logic        lit;

  assign wr_rise = wr_q & ~wr_prev_q;
  assign nib     = disp_data_q[{idx_d, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (seg)
  );

  // Slot sequencer: blank interval, then lit interval, then next digit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 32'd1;
    boundary = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = 32'd0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d  = ST_BLANK;
          cnt_d    = 32'd0;
          idx_d    = idx_q + 3'd1;
          boundary = (idx_q == 3'(NUM_DIGITS - 1));
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // Write capture into shadow; display reloads only at frame boundary.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    sync_d        = 1'b0;
    if (boundary && pending_q) begin
      disp_data_d = shadow_data_q;
      disp_dp_d   = shadow_dp_q;
      pending_d   = 1'b0;
      sync_d      = 1'b1;
    end
    if (wr_rise) begin
      shadow_data_d = data_q;
      shadow_dp_d   = dpm_q;
      pending_d     = 1'b1;
    end
  end

  // Output pattern for the upcoming cycle, registered below.
  always_comb begin
    lit = (state_d == ST_SHOW);
`ifdef SEG7_BLANK_LEADING_EN
    lit = lit && ((idx_d == 3'd0) ||
                  (idx_d <= top_nz_digit(disp_data_q)) ||
                  disp_dp_q[idx_d]);
`endif
    an_d  = ALL_OFF;
    cat_d = ALL_OFF;
    if (lit) begin
      an_d  = ~(8'd1 << idx_d);
      cat_d = {~disp_dp_q[idx_d], seg};
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      idx_q         <= 3'd0;
      cnt_q         <= 32'd0;
      wr_q          <= 1'b0;
      wr_prev_q     <= 1'b0;
      data_q        <= 32'd0;
      dpm_q         <= 8'd0;
      shadow_data_q <= 32'd0;
      shadow_dp_q   <= 8'd0;
      pending_q     <= 1'b0;
      disp_data_q   <= 32'd0;
      disp_dp_q     <= 8'd0;
      an_q          <= ALL_OFF;
      cat_q         <= ALL_OFF;
      sync_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      wr_q          <= bus.wr_en;
      wr_prev_q     <= wr_q;
      data_q        <= bus.wr_data;
      dpm_q         <= bus.dp_mask;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      an_q          <= an_d;
      cat_q         <= cat_d;
      sync_q        <= sync_d;
    end
  end

  assign seg_an     = an_q;
  assign seg_cat    = cat_q;
  assign frame_sync = sync_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLANK_CYCLES=1.
// Slot = 5 cycles, frame = 40 cycles, counted from reset release.
module tb_seg7_scan_driver;

`ifdef SEG7_BLANK_LEADING_EN
  localparam bit LEAD = 1'b1;
`else
  localparam bit LEAD = 1'b0;
`endif

  localparam logic [7:0] HEX_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_an, seg_cat;
  logic       frame_sync;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .SCAN_DIV     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .seg_an     (seg_an),
    .seg_cat    (seg_cat),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [7:0] an_log   [40];
  logic [7:0] cat_log  [40];
  logic       sync_log [40];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_boundary();
    do step(); while (cyc % 40 != 0);
  endtask

  task automatic capture();
    for (int i = 0; i < 40; i++) begin
      if (i != 0) step();
      an_log[i]   = seg_an;
      cat_log[i]  = seg_cat;
      sync_log[i] = frame_sync;
    end
  endtask

  // Expected {anode, cathode} for sample i of a frame showing d/dp.
  function automatic logic [15:0] model(logic [31:0] d, logic [7:0] dp,
                                        int i);
    int s = i / 5;
    int k = i % 5;
    logic lit;
    logic [7:0] c;
    if (k == 0) return 16'hFFFF;
    lit = !LEAD || s == 0 || dp[s] || ((d >> (4 * s)) != 32'd0);
    if (!lit) return 16'hFFFF;
    c = HEX_TAB[d[4*s +: 4]] & (dp[s] ? 8'h7F : 8'hFF);
    return {~(8'd1 << s), c};
  endfunction

  function automatic int frame_diffs(logic [31:0] d, logic [7:0] dp);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      if ({an_log[i], cat_log[i]} !== model(d, dp, i)) n++;
      if (i != 0 && sync_log[i] !== 1'b0) n++;
    end
    return n;
  endfunction

  task automatic do_write(logic [31:0] d, logic [7:0] dp);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.dp_mask = dp;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int nd;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 32'd0;
    bus.dp_mask = 8'd0;
    step();
    step();
    vecs++;
    if (seg_an !== 8'hFF) begin
      errs++;
      $display("FAIL reset_an got %h want ff", seg_an);
    end
    vecs++;
    if (seg_cat !== 8'hFF) begin
      errs++;
      $display("FAIL reset_cat got %h want ff", seg_cat);
    end
    vecs++;
    if (frame_sync !== 1'b0) begin
      errs++;
      $display("FAIL reset_sync got %b want 0", frame_sync);
    end
    rst = 1'b0;
    cyc = 0;
    capture();
    vecs++;
    if (an_log[1] !== 8'hFE || cat_log[1] !== 8'hC0) begin
      errs++;
      $display("FAIL first_show got %h/%h want fe/c0",
               an_log[1], cat_log[1]);
    end
    nd = frame_diffs(32'd0, 8'd0);
    vecs++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL reset_frame got %0d bad samples want 0", nd);
    end
  endtask

  task automatic test_write();
    int nd;
    do_write(32'h1234_ABCD, 8'h01);
    wait_boundary();
    capture();
    vecs++;
    if (sync_log[0] !== 1'b1) begin
      errs++;
      $display("FAIL write_sync got %b want 1", sync_log[0]);
    end
    vecs++;
    if (an_log[1] !== 8'hFE || cat_log[1] !== 8'h21) begin
      errs++;
      $display("FAIL write_d0 got %h/%h want fe/21",
               an_log[1], cat_log[1]);
    end
    vecs++;
    if (cat_log[16] !== 8'h88) begin
      errs++;
      $display("FAIL write_d3 got %h want 88", cat_log[16]);
    end
    vecs++;
    if (an_log[36] !== 8'h7F || cat_log[36] !== 8'hF9) begin
      errs++;
      $display("FAIL write_d7 got %h/%h want 7f/f9",
               an_log[36], cat_log[36]);
    end
    vecs++;
    if (an_log[35] !== 8'hFF || cat_log[35] !== 8'hFF) begin
      errs++;
      $display("FAIL write_blank got %h/%h want ff/ff",
               an_log[35], cat_log[35]);
    end
    nd = frame_diffs(32'h1234_ABCD, 8'h01);
    vecs++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL write_frame got %0d bad samples want 0", nd);
    end
  endtask

  task automatic test_hold();
    int nd;
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hCAFE_0042;
    bus.dp_mask = 8'h80;
    for (int i = 0; i < 20; i++) begin
      step();
      bus.wr_data = 32'h1111_1111 * (i % 15 + 1);
      bus.dp_mask = 8'(i);
    end
    bus.wr_en = 1'b0;
    wait_boundary();
    capture();
    nd = frame_diffs(32'hCAFE_0042, 8'h80);
    vecs++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL hold_frame got %0d bad samples want 0", nd);
    end
    wait_boundary();
    vecs++;
    if (frame_sync !== 1'b0) begin
      errs++;
      $display("FAIL hold_no_resync got %b want 0", frame_sync);
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    do_write(32'h0000_0005, 8'h00);
    step();
    step();
    do_write(32'h0000_000F, 8'h00);
    wait_boundary();
    capture();
    vecs++;
    if (sync_log[0] !== 1'b1 || cat_log[1] !== 8'h8E) begin
      errs++;
      $display("FAIL b2b_d0 got sync=%b cat=%h want 1/8e",
               sync_log[0], cat_log[1]);
    end
    nd = frame_diffs(32'h0000_000F, 8'h00);
    vecs++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL b2b_frame got %0d bad samples want 0", nd);
    end
  endtask

  task automatic test_boundary_write();
    int nd;
    while (cyc % 40 != 38) step();
    do_write(32'h89AB_CDEF, 8'h0F);
    step();
    capture();
    vecs++;
    if (sync_log[0] !== 1'b0) begin
      errs++;
      $display("FAIL edge_no_sync got %b want 0", sync_log[0]);
    end
    nd = frame_diffs(32'h0000_000F, 8'h00);
    vecs++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL edge_old_frame got %0d bad samples want 0", nd);
    end
    wait_boundary();
    capture();
    vecs++;
    if (sync_log[0] !== 1'b1) begin
      errs++;
      $display("FAIL edge_late_sync got %b want 1", sync_log[0]);
    end
    nd = frame_diffs(32'h89AB_CDEF, 8'h0F);
    vecs++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL edge_new_frame got %0d bad samples want 0", nd);
    end
  endtask

  task automatic test_leading();
    int nd;
    logic [7:0] want_an2;
    want_an2 = LEAD ? 8'hFF : 8'hFB;
    do_write(32'h0000_0050, 8'h00);
    wait_boundary();
    capture();
    vecs++;
    if (an_log[6] !== 8'hFD || cat_log[6] !== 8'h92) begin
      errs++;
      $display("FAIL lead_d1 got %h/%h want fd/92",
               an_log[6], cat_log[6]);
    end
    vecs++;
    if (an_log[1] !== 8'hFE || cat_log[1] !== 8'hC0) begin
      errs++;
      $display("FAIL lead_d0 got %h/%h want fe/c0",
               an_log[1], cat_log[1]);
    end
    vecs++;
    if (an_log[11] !== want_an2) begin
      errs++;
      $display("FAIL lead_d2_an got %h want %h", an_log[11], want_an2);
    end
    nd = frame_diffs(32'h0000_0050, 8'h00);
    vecs++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL lead_frame got %0d bad samples want 0", nd);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    do_write(32'h0000_0077, 8'h00);
    while (cyc % 40 != 6) step();
    rst = 1'b1;
    #1;
    vecs++;
    if (seg_an !== 8'hFF || seg_cat !== 8'hFF) begin
      errs++;
      $display("FAIL async_rst got %h/%h want ff/ff", seg_an, seg_cat);
    end
    step();
    rst = 1'b0;
    cyc = 0;
    capture();
    nd = frame_diffs(32'd0, 8'd0);
    vecs++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL rst_frame got %0d bad samples want 0", nd);
    end
    wait_boundary();
    vecs++;
    if (frame_sync !== 1'b0) begin
      errs++;
      $display("FAIL rst_discard got %b want 0", frame_sync);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_hold();
    test_back_to_back();
    test_boundary_write();
    test_leading();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
